// File: rtl/interconnect_link_arbiter.sv
// interconnect_link_arbiter: per-plane round-robin arbiter with burst locking and a one-deep output register
module interconnect_link_arbiter #(
  parameter int NUM_REQUESTERS = 4,
  parameter int NUM_PLANES     = 2,
  parameter int TAG_WIDTH      = 3,
  parameter int DATA_WIDTH     = 32,
  parameter int BURST_LIMIT    = 1
) (
  input  logic                                           clock,
  input  logic                                           reset,
  input  logic [NUM_REQUESTERS*NUM_PLANES-1:0]            in_reqs,
  input  logic [NUM_REQUESTERS*NUM_PLANES*TAG_WIDTH-1:0]  in_tags,
  input  logic [NUM_REQUESTERS*NUM_PLANES*DATA_WIDTH-1:0] in_data,
  output logic [NUM_REQUESTERS*NUM_PLANES-1:0]            in_acks,
  output logic [NUM_PLANES-1:0]                           link_reqs,
  output logic [NUM_PLANES*TAG_WIDTH-1:0]                 link_tags,
  output logic [NUM_PLANES*DATA_WIDTH-1:0]                link_data,
  input  logic [NUM_PLANES-1:0]                           link_acks
);
  localparam int N  = NUM_REQUESTERS;
  localparam int NP = NUM_PLANES;
  localparam int TW = TAG_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int PW = $clog2(N);
  localparam int CW = $clog2(BURST_LIMIT + 1);

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] x);
    return (x == PW'(N - 1)) ? '0 : x + 1'b1;
  endfunction

  for (genvar p = 0; p < NP; p++) begin : g_plane
    logic [N-1:0]  req;
    logic [PW-1:0] ptr_q, ptr_d, own_q, own_d, start, gnt;
    logic [CW-1:0] cnt_q, cnt_d, cnt_n;
    logic          lock_q, lock_d, val_q, val_d, found, accept, xfer;
    logic [TW-1:0] tag_q, tag_d;
    logic [DW-1:0] dat_q, dat_d;
    for (genvar r = 0; r < N; r++) begin : g_req
      assign req[r] = in_reqs[r*NP+p];
      assign in_acks[r*NP+p] = xfer && (gnt == PW'(r));
    end
    assign accept = ~val_q | link_acks[p];
    assign xfer   = accept & found & ~reset;
    // A locked owner that dropped its request hands the scan to the next index
    assign start  = lock_q ? inc(own_q) : ptr_q;
    assign cnt_n  = (lock_q && gnt == own_q) ? cnt_q + 1'b1 : CW'(1);
    // Descending scan so the requester closest to start wins
    always_comb begin
      found = 1'b0;
      gnt   = '0;
      for (int i = N - 1; i >= 0; i--) begin
        if (req[(int'(start) + i) % N]) begin
          found = 1'b1;
          gnt   = PW'((int'(start) + i) % N);
        end
      end
      if (lock_q && req[own_q]) gnt = own_q;
    end
    always_comb begin
      val_d  = val_q & ~link_acks[p];
      ptr_d  = ptr_q;
      own_d  = own_q;
      cnt_d  = cnt_q;
      lock_d = lock_q;
      tag_d  = tag_q;
      dat_d  = dat_q;
      if (lock_q && accept && !req[own_q]) begin
        lock_d = 1'b0;
        ptr_d  = inc(own_q);
      end
      if (xfer) begin
        val_d  = 1'b1;
        tag_d  = in_tags[(int'(gnt)*NP+p)*TW +: TW];
        dat_d  = in_data[(int'(gnt)*NP+p)*DW +: DW];
        own_d  = gnt;
        cnt_d  = cnt_n;
        lock_d = cnt_n != CW'(BURST_LIMIT);
        if (cnt_n == CW'(BURST_LIMIT)) ptr_d = inc(gnt);
      end
    end
    always_ff @(posedge clock) begin
      if (reset) begin
        val_q  <= 1'b0;
        ptr_q  <= '0;
        own_q  <= '0;
        cnt_q  <= '0;
        lock_q <= 1'b0;
        tag_q  <= '0;
        dat_q  <= '0;
      end else begin
        val_q  <= val_d;
        ptr_q  <= ptr_d;
        own_q  <= own_d;
        cnt_q  <= cnt_d;
        lock_q <= lock_d;
        tag_q  <= tag_d;
        dat_q  <= dat_d;
      end
    end
    assign link_reqs[p]             = val_q;
    assign link_tags[p*TW +: TW]    = tag_q;
    assign link_data[p*DW +: DW]    = dat_q;
  end
endmodule

// File: tb/tb_interconnect_link_arbiter.sv
// tb_interconnect_link_arbiter: random stimulus on a round-robin (burst 1) and a burst-3 instance against a reference model
module tb_interconnect_link_arbiter;
  localparam int N  = 4;
  localparam int NP = 2;
  localparam int TW = 3;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N*NP-1:0]    reqs_v[2], acks_o[2], pend[2];
  logic [N*NP*TW-1:0] tags_v[2];
  logic [N*NP*DW-1:0] data_v[2];
  logic [NP-1:0]      lack_v[2], lreq[2];
  logic [NP*TW-1:0]   ltag[2];
  logic [NP*DW-1:0]   ldat[2];

  int n_tests = 0;
  int n_fail  = 0;

  int            m_ptr[2][NP], m_own[2][NP], m_cnt[2][NP];
  bit            m_lock[2][NP], m_val[2][NP];
  logic [TW-1:0] m_tag[2][NP];
  logic [DW-1:0] m_dat[2][NP];

  interconnect_link_arbiter #(.NUM_REQUESTERS(N), .NUM_PLANES(NP), .TAG_WIDTH(TW), .DATA_WIDTH(DW), .BURST_LIMIT(1)) u_rr (
    .clock(clk), .reset(rst), .in_reqs(reqs_v[0]), .in_tags(tags_v[0]), .in_data(data_v[0]), .in_acks(acks_o[0]),
    .link_reqs(lreq[0]), .link_tags(ltag[0]), .link_data(ldat[0]), .link_acks(lack_v[0]));
  interconnect_link_arbiter #(.NUM_REQUESTERS(N), .NUM_PLANES(NP), .TAG_WIDTH(TW), .DATA_WIDTH(DW), .BURST_LIMIT(3)) u_bl3 (
    .clock(clk), .reset(rst), .in_reqs(reqs_v[1]), .in_tags(tags_v[1]), .in_data(data_v[1]), .in_acks(acks_o[1]),
    .link_reqs(lreq[1]), .link_tags(ltag[1]), .link_data(ldat[1]), .link_acks(lack_v[1]));

  function automatic int burst(int d);
    return d == 0 ? 1 : 3;
  endfunction

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic int winner(int d, int p);
    bit [N-1:0] rq;
    int s;
    for (int r = 0; r < N; r++) rq[r] = reqs_v[d][r*NP+p];
    if (rst || (m_val[d][p] && !lack_v[d][p])) return -1;
    if (m_lock[d][p] && rq[m_own[d][p]]) return m_own[d][p];
    s = m_lock[d][p] ? (m_own[d][p] + 1) % N : m_ptr[d][p];
    for (int i = 0; i < N; i++)
      if (rq[(s + i) % N]) return (s + i) % N;
    return -1;
  endfunction

  task automatic model_step(int d, int p, int w);
    bit own_rq, was_lock, acc;
    if (rst) begin
      m_val[d][p] = 0; m_lock[d][p] = 0; m_ptr[d][p] = 0; m_own[d][p] = 0; m_cnt[d][p] = 0;
      m_tag[d][p] = '0; m_dat[d][p] = '0;
      return;
    end
    own_rq   = reqs_v[d][m_own[d][p]*NP+p];
    was_lock = m_lock[d][p];
    acc      = !m_val[d][p] || lack_v[d][p];
    if (m_val[d][p] && lack_v[d][p]) m_val[d][p] = 0;
    if (was_lock && acc && !own_rq) begin
      m_lock[d][p] = 0;
      m_ptr[d][p]  = (m_own[d][p] + 1) % N;
    end
    if (w >= 0) begin
      m_tag[d][p] = tags_v[d][(w*NP+p)*TW +: TW];
      m_dat[d][p] = data_v[d][(w*NP+p)*DW +: DW];
      m_val[d][p] = 1;
      m_cnt[d][p] = (was_lock && w == m_own[d][p]) ? m_cnt[d][p] + 1 : 1;
      m_own[d][p] = w;
      if (m_cnt[d][p] == burst(d)) begin
        m_lock[d][p] = 0;
        m_ptr[d][p]  = (w + 1) % N;
      end else m_lock[d][p] = 1;
    end
  endtask

  // fm: requesters that always request; pct: chance others request; ap0/ap1: link ack chance; rp: reset chance
  task automatic run(int n, bit [N-1:0] fm, int pct, int ap0, int ap1, int rp);
    int ws[NP];
    logic [N*NP-1:0] exp;
    repeat (n) begin
      rst = ($urandom_range(99) < rp);
      for (int d = 0; d < 2; d++) begin
        for (int r = 0; r < N; r++)
          for (int p = 0; p < NP; p++)
            if (!pend[d][r*NP+p]) begin
              reqs_v[d][r*NP+p] = fm[r] || ($urandom_range(99) < pct);
              if (reqs_v[d][r*NP+p]) begin
                tags_v[d][(r*NP+p)*TW +: TW] = TW'($urandom);
                data_v[d][(r*NP+p)*DW +: DW] = DW'($urandom);
              end
            end
        lack_v[d][0] = ($urandom_range(99) < ap0);
        lack_v[d][1] = ($urandom_range(99) < ap1);
      end
      #1;
      for (int d = 0; d < 2; d++) begin
        exp = '0;
        for (int p = 0; p < NP; p++) begin
          ws[p] = winner(d, p);
          if (ws[p] >= 0) exp[ws[p]*NP+p] = 1'b1;
        end
        check("in_acks", 64'(acks_o[d]), 64'(exp));
        for (int p = 0; p < NP; p++) begin
          check("link_req", 64'(lreq[d][p]), 64'(m_val[d][p]));
          check("link_tag", 64'(ltag[d][p*TW +: TW]), 64'(m_tag[d][p]));
          check("link_data", 64'(ldat[d][p*DW +: DW]), 64'(m_dat[d][p]));
        end
        pend[d] = reqs_v[d] & ~exp;
        for (int p = 0; p < NP; p++) model_step(d, p, ws[p]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      reqs_v[d] = '0; tags_v[d] = '0; data_v[d] = '0; lack_v[d] = '0; pend[d] = '0;
      for (int p = 0; p < NP; p++) begin
        m_tag[d][p] = '0;
        m_dat[d][p] = '0;
      end
    end
    @(posedge clk);
    #1;
    run(3, 4'hF, 0, 100, 100, 100);
    run(12, 4'hF, 0, 100, 100, 0);
    run(14, 4'b0110, 0, 100, 100, 0);
    run(10, 4'b0110, 30, 100, 100, 0);
    run(5, 4'hF, 0, 0, 100, 0);
    run(6, 4'hF, 0, 100, 100, 0);
    run(4, 4'hF, 0, 0, 100, 0);
    run(2, 4'hF, 0, 50, 50, 100);
    run(12, 4'b1000, 0, 100, 100, 0);
    run(300, 4'b0000, 40, 70, 70, 2);
    run(200, 4'b0000, 80, 40, 90, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/interconnect_link_arbiter.md
# interconnect_link_arbiter

Round-robin arbiter and one-deep output register that shares one outbound interconnect link among NUM_REQUESTERS local senders (PE output channels, router ports), independently per physical plane. Each plane grants one requester per transfer, with optional burst locking so a winner can send up to BURST_LIMIT consecutive packets before rotation. The link-side outputs connect directly to the sender modport of an interconnect link; unused requester inputs are tied low.

## Interface
- NUM_REQUESTERS, 4, senders sharing the link (≥2)
- NUM_PLANES, TIA_NUM_PHYSICAL_PLANES, independent physical planes
- TAG_WIDTH, TIA_TAG_WIDTH, tag bits per packet
- DATA_WIDTH, TIA_WORD_WIDTH, data bits per packet
- BURST_LIMIT, 1, max consecutive transfers per grant (≥1; 1 = pure round-robin)
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_reqs  in  NUM_REQUESTERS*NUM_PLANES  request; bit r*NUM_PLANES+p = requester r, plane p
- in_tags  in  NUM_REQUESTERS*NUM_PLANES*TAG_WIDTH  tag per (r,p), same indexing
- in_data  in  NUM_REQUESTERS*NUM_PLANES*DATA_WIDTH  data per (r,p)
- in_acks  out  NUM_REQUESTERS*NUM_PLANES  combinational accept per (r,p)
- link_reqs  out  NUM_PLANES  outbound request per plane (registered)
- link_tags  out  NUM_PLANES*TAG_WIDTH  outbound tag per plane (registered)
- link_data  out  NUM_PLANES*DATA_WIDTH  outbound data per plane (registered)
- link_acks  in  NUM_PLANES  downstream accept per plane

## Operation
- Planes fully independent; per-plane state: out_valid (drives link_reqs[p]), tag/data register, rr pointer ptr (clog2(NUM_REQUESTERS) bits), locked, owner, burst count cnt (clog2(BURST_LIMIT+1) bits).
- Transfer on a side = req & ack high at rising edge. Requesters hold tag/data stable while req high and unacked.
- accept = ~out_valid | link_acks[p].
- Grant selection (combinational): if locked and in_reqs[owner] → owner; else first requesting r scanning ptr, ptr+1, … mod NUM_REQUESTERS, where scan start is owner+1 if locked (owner dropped its request). No request → no grant.
- in_acks[r,p] = accept & grant==r & ~reset; at most one per plane.
- On input transfer from w: load tag/data, out_valid←1. If locked and w==owner: cnt←cnt+1. Else owner←w, cnt←1. If new cnt==BURST_LIMIT: locked←0, ptr←w+1 mod N; else locked←1.
- Locked, accept high, owner not requesting: locked←0, ptr←owner+1 (overridden by the rule above if another requester transfers that cycle).
- link_acks[p] with no input transfer: out_valid←0; register contents retained but ignored.
- link_acks[p] while out_valid=0 is ignored.
- in_reqs unasserted: no state change beyond the locked release above.

## Timing
- Reset values: link_reqs=0, link_tags=0, link_data=0, in_acks=0, ptr=0, locked=0, owner=0, cnt=0. Reset mid-transfer discards the held packet; no ack issued in reset cycles.
- Latency: input transfer at edge t → link_reqs high with that packet from t to the edge of its link_ack.
- Throughput: one packet per cycle per plane when link_acks stays high (drain and refill same edge).
- Backpressure: link_acks low with out_valid=1 → accept=0, all in_acks low, packet held stable.
- Arbitration is purely combinational on in_reqs; in_acks may depend combinationally on link_acks (no register in that path).

## Test plan
- N=4, BURST_LIMIT=1, link_acks=1, all four requesters constant on plane 0 → grants 0,1,2,3,0,… one per cycle; link_tags follow one cycle later.
- BURST_LIMIT=3, requesters 1 and 2 constant → grants 1,1,1,2,2,2,1…; requester 1 drops after 2 sends → lock releases, next grant 2 same cycle.
- link_acks[0]=0 for 5 cycles with packet tag=5,data=0xA5 held → link outputs stable, in_acks all 0; ack → next packet loaded same edge.
- Plane 0 backpressured, plane 1 free-flowing → plane 1 throughput unaffected, grants independent.
- Assert reset while out_valid=1 and locked → next cycle link_reqs=0, ptr=0; first grant after reset goes to lowest requesting index.
- Single requester 3 alone, BURST_LIMIT=1 → granted every cycle (wrap ptr 0→…→3 search), no bubbles.
